// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status encoding and the memory arbiter's grant states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } arb_state_t;

  localparam int DSTARVE_MAX_DEF = 4;

endpackage

// File: rtl/starve_counter.sv
// Saturating 4-bit event counter; clear wins over increment.
module starve_counter
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (inc && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache: data-side priority,
// grant hold across multi-word transactions, bounded icache starvation.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int DSTARVE_MAX = DSTARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [3:0]        starve_cnt
);

  arb_state_t state;
  logic       d_req;
  logic       complete;
  logic       starve_hit;
  logic       cnt_inc;
  logic       cnt_clr;

  assign d_req      = dREN | dWEN;
  assign complete   = (ramstate == ACCESS);
  // True when the data word completing now would be the last one the icache tolerates.
  assign starve_hit = (({1'b0, starve_cnt} + 5'd1) == 5'(DSTARVE_MAX));
  assign cnt_inc    = (state == GNT_D) && complete && iREN;
  assign cnt_clr    = !iREN || ((state == GNT_I) && complete);

  starve_counter u_starve (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (starve_cnt)
  );

  // Grants change only on an owner's request drop or on a completion cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (d_req)     state <= GNT_D;
          else if (iREN) state <= GNT_I;
        end
        GNT_D: begin
          if (!d_req)                           state <= iREN ? GNT_I : IDLE;
          else if (complete && iREN && starve_hit) state <= GNT_I;
        end
        GNT_I: begin
          if (!iREN)                  state <= d_req ? GNT_D : IDLE;
          else if (complete && d_req) state <= GNT_D;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      GNT_D: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = !complete;
      end
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !complete;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a RAM model and a per-cycle reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int DSTARVE_MAX = 4;
  localparam int M_IDLE = 0, M_D = 1, M_I = 2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [1:0]  ramstate;
  logic [3:0]  starve_cnt;

  int passCount = 0;
  int checkCount = 0;

  // RAM model: ramLat BUSY cycles then one ACCESS per word; errHold forces ERROR.
  int          ramLat = 2;
  logic        errHold = 1'b0;
  int          lat;
  logic [31:0] ramMem [0:255];

  mem_arbiter #(.WORD_W(32), .DSTARVE_MAX(DSTARVE_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .starve_cnt(starve_cnt)
  );

  always #5 CLK = ~CLK;

  assign ramstate = !(ramREN || ramWEN) ? 2'd0 : errHold ? 2'd3 : (lat == ramLat) ? 2'd2 : 2'd1;
  assign ramload  = ramMem[ramaddr[9:2]];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat <= 0;
      for (int i = 0; i < 256; i++)
        ramMem[i] <= (i == 16) ? 32'hDEADBEEF : {16'hA5A5, 6'd0, 8'(i), 2'd0};
    end else if ((ramREN || ramWEN) && !errHold) begin
      if (lat == ramLat) begin
        lat <= 0;
        if (ramWEN) ramMem[ramaddr[9:2]] <= ramstore;
      end else begin
        lat <= lat + 1;
      end
    end else if (!(ramREN || ramWEN)) begin
      lat <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
  endtask

  // Counts cycles (current one included) until the chosen side sees its wait drop.
  task automatic waitDone(input bit dataSide, input string name, output int cycles, output logic [31:0] ld);
    cycles = 0;
    ld = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      cycles++;
      if (dataSide ? !dwait : !iwait) begin
        ld = dataSide ? dload : iload;
        tick();
        return;
      end
      tick();
    end
    checkOutput({name, " timeout"}, 32'd0, 32'd1);
  endtask

  // Reference model: memory contents expected behind each address.
  logic [31:0] mMem [logic [31:0]];

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mMem.exists(a)) return mMem[a];
    return pattern(a);
  endfunction

  int          mOwner, mNext, mStarve, sNext;
  logic        dReq, done, wrPend;
  logic [31:0] wrA, wrD;
  logic        expRen, expWen, expIw, expDw;
  logic [31:0] expAddr, expStore;

  initial begin
    mOwner = M_IDLE;
    mStarve = 0;
    forever begin
      @(negedge CLK);
      wrPend = 1'b0;
      if (!nRST) begin
        mOwner = M_IDLE;
        mStarve = 0;
        mMem.delete();
      end
      dReq = dREN || dWEN;
      done = (ramstate == 2'd2);
      expRen = 1'b0; expWen = 1'b0; expAddr = '0; expStore = '0; expIw = 1'b1; expDw = 1'b1;
      if (mOwner == M_D) begin
        expRen = dREN; expWen = dWEN; expAddr = daddr; expStore = dstore; expDw = !done;
      end else if (mOwner == M_I) begin
        expRen = iREN; expAddr = iaddr; expIw = !done;
      end
      checkOutput("cmp ramREN", 32'(ramREN), 32'(expRen));
      checkOutput("cmp ramWEN", 32'(ramWEN), 32'(expWen));
      checkOutput("cmp ramaddr", ramaddr, expAddr);
      checkOutput("cmp ramstore", ramstore, expStore);
      checkOutput("cmp iwait", 32'(iwait), 32'(expIw));
      checkOutput("cmp dwait", 32'(dwait), 32'(expDw));
      checkOutput("cmp starve_cnt", 32'(starve_cnt), 32'(mStarve));
      if (mOwner == M_IDLE) begin
        checkOutput("cmp idle iload", iload, 32'd0);
        checkOutput("cmp idle dload", dload, 32'd0);
      end
      if (mOwner == M_I && done) checkOutput("cmp iload", iload, memRead(iaddr));
      if (mOwner == M_D && done && dREN) checkOutput("cmp dload", dload, memRead(daddr));
      if (mOwner == M_D && done && dWEN) begin
        wrPend = 1'b1; wrA = daddr; wrD = dstore;
      end
      mNext = mOwner;
      if (mOwner == M_IDLE) mNext = dReq ? M_D : (iREN ? M_I : M_IDLE);
      else if (mOwner == M_D) begin
        if (!dReq) mNext = iREN ? M_I : M_IDLE;
        else if (done && iREN && (mStarve + 1 == DSTARVE_MAX)) mNext = M_I;
      end else begin
        if (!iREN) mNext = dReq ? M_D : M_IDLE;
        else if (done && dReq) mNext = M_D;
      end
      if (!iREN) sNext = 0;
      else if (mOwner == M_I && done) sNext = 0;
      else if (mOwner == M_D && done) sNext = (mStarve < 15) ? mStarve + 1 : 15;
      else sNext = mStarve;
      @(posedge CLK);
      if (nRST) begin
        mOwner = mNext;
        mStarve = sNext;
        if (wrPend) mMem[wrA] = wrD;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  int          cyc, dDone;
  logic [31:0] ld;

  initial begin
    tick();
    tick();
    checkOutput("reset iwait", 32'(iwait), 32'd1);
    checkOutput("reset dwait", 32'(dwait), 32'd1);
    checkOutput("reset ramREN", 32'(ramREN), 32'd0);
    checkOutput("reset ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("reset ramaddr", ramaddr, 32'd0);
    checkOutput("reset starve_cnt", 32'(starve_cnt), 32'd0);
    checkOutput("reset iload", iload, 32'd0);
    checkOutput("reset dload", dload, 32'd0);
    nRST = 1'b1;
    tick();

    // Lone icache read, two BUSY cycles before ACCESS.
    ramLat = 2;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    waitDone(1'b0, "lone iread", cyc, ld);
    checkOutput("lone iread cycle", 32'(cyc), 32'd4);
    checkOutput("lone iread data", ld, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Simultaneous requests: data first, then icache with no idle gap.
    ramLat = 1;
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h80, 32'h0);
    @(negedge CLK);
    checkOutput("simul arb cycle ramREN", 32'(ramREN), 32'd0);
    tick();
    @(negedge CLK);
    checkOutput("simul d ramaddr", ramaddr, 32'h80);
    checkOutput("simul d ramREN", 32'(ramREN), 32'd1);
    tick();
    waitDone(1'b1, "simul dread", cyc, ld);
    checkOutput("simul dread data", ld, 32'hA5A50080);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h0);
    @(negedge CLK);
    checkOutput("simul starve after d", 32'(starve_cnt), 32'd1);
    tick();
    @(negedge CLK);
    checkOutput("simul i ramaddr", ramaddr, 32'h44);
    checkOutput("simul i ramREN", 32'(ramREN), 32'd1);
    waitDone(1'b0, "simul iread", cyc, ld);
    checkOutput("simul iread data", ld, 32'hA5A50044);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Four-word dcache burst with grant held across words.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h11111111);
    waitDone(1'b1, "burst w0", cyc, ld);
    checkOutput("burst w0 cycles", 32'(cyc), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h104, 32'h22222222);
    waitDone(1'b1, "burst w1", cyc, ld);
    checkOutput("burst w1 cycles", 32'(cyc), 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    waitDone(1'b1, "burst r0", cyc, ld);
    checkOutput("burst r0 cycles", 32'(cyc), 32'd2);
    checkOutput("burst r0 data", ld, 32'h11111111);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);
    waitDone(1'b1, "burst r1", cyc, ld);
    checkOutput("burst r1 cycles", 32'(cyc), 32'd2);
    checkOutput("burst r1 data", ld, 32'h22222222);
    checkOutput("burst starve_cnt", 32'(starve_cnt), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Starvation: continuous data request, icache pending.
    ramLat = 0;
    applyStimulus(1'b1, 32'h48, 1'b1, 1'b0, 32'h90, 32'h0);
    dDone = 0;
    cyc = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (!dwait) dDone++;
      if (!iwait) begin
        cyc = 1;
        checkOutput("starve cnt at igrant", 32'(starve_cnt), 32'd4);
        break;
      end
      tick();
    end
    checkOutput("starve igrant reached", 32'(cyc), 32'd1);
    checkOutput("starve data words", 32'(dDone), 32'd4);
    tick();
    @(negedge CLK);
    checkOutput("starve back to d", 32'(dwait), 32'd0);
    checkOutput("starve cnt cleared", 32'(starve_cnt), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Reset in the middle of a BUSY data access.
    ramLat = 3;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);
    tick();
    #1;
    checkOutput("midreset granted", 32'(ramREN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    checkOutput("midreset ramREN", 32'(ramREN), 32'd0);
    checkOutput("midreset ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("midreset dwait", 32'(dwait), 32'd1);
    checkOutput("midreset iwait", 32'(iwait), 32'd1);
    tick();
    nRST = 1'b1;
    @(negedge CLK);
    checkOutput("postreset idle ramREN", 32'(ramREN), 32'd0);
    tick();
    waitDone(1'b1, "postreset dread", cyc, ld);
    checkOutput("postreset dread cycles", 32'(cyc), 32'd4);
    checkOutput("postreset dread data", ld, 32'hA5A50084);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ERROR status for three cycles, then ACCESS.
    ramLat = 0;
    errHold = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D);
    cyc = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (!dwait) break;
      if (cyc >= 2) checkOutput("error grant held", 32'(ramWEN), 32'd1);
      tick();
      cyc++;
      if (cyc == 5) errHold = 1'b0;
    end
    checkOutput("error completion cycle", 32'(cyc), 32'd5);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    waitDone(1'b1, "error readback", cyc, ld);
    checkOutput("error readback data", ld, 32'hCAFEF00D);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port RAM arbiter between the instruction cache and the data cache.
- Registered grant FSM with data-side priority, grant hold for multi-word cache transactions, and a bounded-starvation rule for the instruction side.
- Sits between the cache pair and the RAM model; replaces the purely combinational memory control path.
- Each cache sees one wait signal, deasserted for exactly the cycle its word completes.

Parameters:
- WORD_W, 32, data and address width.
- DSTARVE_MAX, 4, maximum consecutive data-side completed words while an instruction request is pending before the grant is forced to the icache (1..15).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; one clock, reset is asynchronous and active-low
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache word address
- iload  out  WORD_W  icache read data
- iwait  out  1  icache stall; low for the single completing cycle
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request (dREN and dWEN are never both high)
- daddr  in  WORD_W  dcache word address
- dstore  in  WORD_W  dcache write data
- dload  out  WORD_W  dcache read data
- dwait  out  1  dcache stall; low for the single completing cycle
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- starve_cnt  out  4  current count of consecutive data-side completions with iREN pending (debug/perf)

Behaviour:
- Reset (async, nRST low):
  - State IDLE; starve_cnt=0.
  - All RAM strobes, ramaddr and ramstore are 0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - Reset asserted mid-transaction aborts it immediately; the RAM sees its strobes drop in the same cycle.
- States: IDLE, GNT_D, GNT_I.
- IDLE: no RAM strobes; both waits high.
  - Next GNT_D if (dREN|dWEN).
  - Else GNT_I if iREN.
  - Else stay IDLE.
  - Arbitration costs exactly one cycle from IDLE.
- GNT_D:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore; dload=ramload.
  - dwait = !(ramstate==ACCESS); iwait=1.
- GNT_I:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0, ramstore=0; iload=ramload.
  - iwait = !(ramstate==ACCESS); dwait=1.
- Grant hold: the owner keeps the grant while its request stays high. Back-to-back words (e.g. two-word writeback followed by two-word fetch) proceed with no arbitration bubble.
- Release from GNT_D, evaluated only when the data request drops, or on a completion cycle (ramstate==ACCESS):
  - If the data request drops: next GNT_I if iREN, else IDLE.
  - If on a completion cycle iREN is high and starve_cnt+1 == DSTARVE_MAX: next GNT_I, even though the data request is still high. The dcache re-presents its address, so the interrupted burst resumes later.
- Release from GNT_I:
  - When iREN drops: next GNT_D if (dREN|dWEN), else IDLE.
  - On an icache completion with the data request pending: next GNT_D (the icache gets one word per forced grant).
- starve_cnt:
  - Increments on each GNT_D completion while iREN is high.
  - Clears on any GNT_I completion and whenever iREN is low.
  - Saturates at 15.
- No grant change ever occurs in a cycle where ramstate==BUSY; a grant change only happens on a completion or a request-drop edge.
- ramstate==ERROR: treated as not-complete (wait stays high), the grant is held, and the request is retried each cycle.
- Simultaneous iREN and data request from IDLE: the data side wins.
- Owner request dropping in the same cycle as its completion: the completion is delivered (wait low), then release is processed as above.

Decomposition:
- Shared package cpu_types_pkg:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR); it is already present and is reused.
  - New arb_state_t enum {IDLE, GNT_D, GNT_I}.
  - Constant DSTARVE_MAX_DEF=4.
- Sub-module starve_counter: saturating 4-bit counter with inc/clr/saturate, instantiated once.
- Grant FSM and output mux stay in mem_arbiter.

Test Plan:
- Lone icache read: iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF.
  - Required: 1-cycle IDLE→GNT_I, iwait low on exactly cycle 4, iload=0xDEADBEEF, dwait held high throughout.
- Simultaneous requests: iREN=1 and dREN=1 (daddr=0x80) in the same cycle.
  - Required: GNT_D first, ramaddr=0x80; after dREN drops, GNT_I with no IDLE cycle, ramaddr=iaddr.
- Dcache 4-word burst (2 writes to 0x100/0x104, then 2 reads) with iREN low.
  - Required: grant held for all 4 words, no bubble, starve_cnt stays 0.
- Starvation with DSTARVE_MAX=4: dREN held high continuously, iREN high.
  - Required: after the 4th data completion the grant moves to GNT_I; one icache word completes; the grant returns to GNT_D; starve_cnt 4→0.
- Reset mid-transaction: nRST pulled low while GNT_D with ramstate=BUSY.
  - Required: ramREN/ramWEN go 0 asynchronously, both waits 1; after release, state IDLE.
- ERROR status: ramstate=ERROR for 3 cycles, then ACCESS.
  - Required: dwait stays high through the ERROR cycles, the grant does not change, completion occurs on the ACCESS cycle.
